// File: rtl/store_buffer_if.sv
// Store-buffer bus: pipeline store/load-hazard port plus the memory write request port.
// The slave modport is the buffer; the master modport drives it.
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  DMOp;
  logic        st_ready;
  logic        st_err;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        m_data_req;
  logic        m_data_gnt;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        empty;

  modport slave (
    input  st_valid, st_addr, st_data, DMOp, ld_addr, m_data_gnt,
    output st_ready, st_err, ld_hit, m_data_req, m_data_addr, m_data_wdata,
           m_data_byteen, empty
  );

  modport master (
    output st_valid, st_addr, st_data, DMOp, ld_addr, m_data_gnt,
    input  st_ready, st_err, ld_hit, m_data_req, m_data_addr, m_data_wdata,
           m_data_byteen, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Two-entry store buffer: formats stores into word-aligned, lane-replicated
// memory writes, issues them in order, and flags loads that hit a pending store.
module store_buffer (
  input  logic            clk,
  input  logic            reset,
  store_buffer_if.slave   bus
);
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } entry_t;

  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_BYTE = 2'b10;

  entry_t     entry_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q,  count_d;
  entry_t     new_entry;
  logic       enq, deq;
  logic       ld_addr_unused;

  assign bus.st_err = bus.st_valid &
                      ((bus.DMOp == 2'b11) |
                       ((bus.DMOp == OP_WORD) & (bus.st_addr[1:0] != 2'b00)) |
                       ((bus.DMOp == OP_HALF) & bus.st_addr[0]));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    new_entry.addr   = {bus.st_addr[31:2], 2'b00};
    new_entry.wdata  = bus.st_data;
    new_entry.byteen = 4'b0000;
    unique case (bus.DMOp)
      OP_WORD: new_entry.byteen = 4'b1111;
      OP_HALF: begin
        new_entry.wdata  = {2{bus.st_data[15:0]}};
        new_entry.byteen = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_BYTE: begin
        new_entry.wdata  = {4{bus.st_data[7:0]}};
        new_entry.byteen = 4'b0001 << bus.st_addr[1:0];
      end
      default: new_entry.byteen = 4'b0000;
    endcase
  end

  // No bypass into a full buffer: st_ready ignores a same-cycle dequeue.
  assign bus.st_ready = (count_q != 2'd2);
  assign bus.empty    = (count_q == 2'd0);
  assign bus.m_data_req = !bus.empty;
  assign enq = bus.st_valid & bus.st_ready & ~bus.st_err;
  assign deq = bus.m_data_req & bus.m_data_gnt;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = ~wr_ptr_q;
    if (deq) rd_ptr_d = ~rd_ptr_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the entry array is reset as well, because the memory outputs are read straight from the head entry and must read 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq) entry_q[wr_ptr_q] <= new_entry;
    end
  end

  assign bus.m_data_addr   = entry_q[rd_ptr_q].addr;
  assign bus.m_data_wdata  = entry_q[rd_ptr_q].wdata;
  assign bus.m_data_byteen = entry_q[rd_ptr_q].byteen;

  // An entry is live when the buffer is full, or it is the head of a one-entry buffer.
  always_comb begin
    bus.ld_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)))) &&
          (entry_q[i].addr[31:2] == bus.ld_addr[31:2]))
        bus.ld_hit = 1'b1;
    end
  end

  assign ld_addr_unused = ^bus.ld_addr[1:0];
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer, checked against a queue-based
// reference model of the buffered stores.
module tb_store_buffer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  store_buffer_if bus ();

  store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } ent_t;

  ent_t model_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic v, input logic [31:0] a, input logic [1:0] op);
    return v && ((op == 2'd3) || (op == 2'd0 && a[1:0] != 2'd0) || (op == 2'd1 && a[0]));
  endfunction

  function automatic ent_t make_entry(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] op);
    ent_t e;
    e.addr = a & 32'hFFFF_FFFC;
    case (op)
      2'd0: begin e.wdata = d; e.byteen = 4'hF; end
      2'd1: begin e.wdata = (d & 32'hFFFF) * 32'h0001_0001; e.byteen = a[1] ? 4'hC : 4'h3; end
      default: begin e.wdata = (d & 32'hFF) * 32'h0101_0101; e.byteen = 4'(1 << a[1:0]); end
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] op, input logic g, input logic [31:0] ld);
    bus.st_valid   = v;
    bus.st_addr    = a;
    bus.st_data    = d;
    bus.DMOp       = op;
    bus.m_data_gnt = g;
    bus.ld_addr    = ld;
  endtask

  // Check all outputs mid-cycle against the model, then advance model and DUT one edge.
  task automatic eval();
    logic err, hit, do_enq, do_deq;
    @(negedge clk);
    err = exp_err(bus.st_valid, bus.st_addr, bus.DMOp);
    hit = 1'b0;
    foreach (model_q[i]) if (model_q[i].addr[31:2] == bus.ld_addr[31:2]) hit = 1'b1;
    check("st_err",     32'(bus.st_err),     32'(err));
    check("st_ready",   32'(bus.st_ready),   32'(model_q.size() < 2));
    check("empty",      32'(bus.empty),      32'(model_q.size() == 0));
    check("m_data_req", 32'(bus.m_data_req), 32'(model_q.size() != 0));
    check("ld_hit",     32'(bus.ld_hit),     32'(hit));
    if (model_q.size() != 0) begin
      check("m_data_addr",   bus.m_data_addr,        model_q[0].addr);
      check("m_data_wdata",  bus.m_data_wdata,       model_q[0].wdata);
      check("m_data_byteen", 32'(bus.m_data_byteen), 32'(model_q[0].byteen));
    end
    do_enq = bus.st_valid && !err && (model_q.size() < 2);
    do_deq = bus.m_data_gnt && (model_q.size() != 0);
    @(posedge clk);
    if (do_deq) void'(model_q.pop_front());
    if (do_enq) model_q.push_back(make_entry(bus.st_addr, bus.st_data, bus.DMOp));
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_req",    32'(bus.m_data_req), 32'd0);
    check("rst_empty",  32'(bus.empty),      32'd1);
    check("rst_ready",  32'(bus.st_ready),   32'd1);
    check("rst_ld_hit", 32'(bus.ld_hit),     32'd0);
    check("rst_addr",   bus.m_data_addr,     32'd0);
    check("rst_wdata",  bus.m_data_wdata,    32'd0);
    check("rst_byteen", 32'(bus.m_data_byteen), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Byte store accepted on the first edge after release.
    drive(1'b1, 32'h1003, 32'h0000_00AB, 2'd2, 1'b0, 32'h1003);
    eval();
    check("sb_req",    32'(bus.m_data_req), 32'd1);
    check("sb_addr",   bus.m_data_addr,     32'h1000);
    check("sb_wdata",  bus.m_data_wdata,    32'hABAB_ABAB);
    check("sb_byteen", 32'(bus.m_data_byteen), 32'b1000);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0);
    eval();

    // Halfword formatting, then a misaligned word is rejected.
    drive(1'b1, 32'h2002, 32'h0000_1234, 2'd1, 1'b0, 32'h0);
    eval();
    check("sh_wdata",  bus.m_data_wdata,       32'h1234_1234);
    check("sh_byteen", 32'(bus.m_data_byteen), 32'b1100);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0);
    eval();
    drive(1'b1, 32'h2002, 32'hDEAD_BEEF, 2'd0, 1'b0, 32'h0);
    #1 check("sw_mis_err", 32'(bus.st_err), 32'd1);
    eval();
    check("sw_mis_empty", 32'(bus.empty), 32'd1);

    // Fill to capacity, third store held off, then drain in order.
    drive(1'b1, 32'h10, 32'h1111_1111, 2'd0, 1'b0, 32'h0);
    eval();
    drive(1'b1, 32'h14, 32'h2222_2222, 2'd0, 1'b0, 32'h0);
    eval();
    check("full_ready", 32'(bus.st_ready), 32'd0);
    drive(1'b1, 32'h18, 32'h3333_3333, 2'd0, 1'b0, 32'h0);
    eval();
    check("full_head", bus.m_data_addr, 32'h10);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0);
    eval();
    check("drain_2nd", bus.m_data_addr, 32'h14);
    eval();
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_req",   32'(bus.m_data_req), 32'd0);

    // Simultaneous enqueue and dequeue at occupancy 1.
    drive(1'b1, 32'h20, 32'hAAAA_0000, 2'd0, 1'b0, 32'h0);
    eval();
    drive(1'b1, 32'h24, 32'hBBBB_0000, 2'd0, 1'b1, 32'h0);
    eval();
    check("swap_head",  bus.m_data_addr,     32'h24);
    check("swap_ready", 32'(bus.st_ready),   32'd1);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0);
    eval();

    // Load hazard against a pending store.
    drive(1'b1, 32'h3000, 32'h5555_5555, 2'd0, 1'b0, 32'h0);
    eval();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h3002);
    #1 check("hit_same_word", 32'(bus.ld_hit), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h3004);
    #1 check("hit_next_word", 32'(bus.ld_hit), 32'd0);

    // Asynchronous reset with two entries pending and grant asserted.
    drive(1'b1, 32'h3004, 32'h6666_6666, 2'd0, 1'b0, 32'h0);
    eval();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0);
    #2 reset = 1'b0;
    #1;
    check("arst_req",   32'(bus.m_data_req), 32'd0);
    check("arst_empty", 32'(bus.empty),      32'd1);
    check("arst_addr",  bus.m_data_addr,     32'd0);
    model_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    check("arst_release_empty", 32'(bus.empty), 32'd1);

    // Randomized traffic over a small address pool so hazards and reuse occur.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 1)),
            32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3),
            $urandom,
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) == 0),
            32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3));
      eval();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
